hazard_controller: RTL and testbench

- Pipeline control block that sequences the decode stage.
- Keeps a per-register pending-write scoreboard.
- Generates the stall, flush and read-enable controls that the decode stage and register file consume.
- Sits beside the decode stage; is driven by decode-side operand info, a retire/writeback stage, and the execute-stage branch redirect.

---
 rtl/hazard_controller_pkg.sv | 23 ++
 rtl/hc_scoreboard.sv | 57 +++++
 rtl/hazard_controller.sv | 133 +++++++++++++
 tb/tb_hazard_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the decode-stage hazard controller: FSM state
// encoding, flush-counter sizing and the default flush length.
package hazard_controller_pkg;

  // FSM state encoding shared by the controller and anything that probes it.
  localparam int HC_STATE_WIDTH = 1;

  typedef enum logic [HC_STATE_WIDTH-1:0] {
    HC_IDLE  = 1'b0,
    HC_FLUSH = 1'b1
  } hc_state_e;

  // Flush length is 1..15 cycles, so a 4-bit down-counter always suffices.
  localparam int HC_DEFAULT_FLUSH_CYCLES = 2;
  localparam int HC_FLUSH_CNT_WIDTH      = 4;

  // Value loaded into the flush counter on a redirect. The counter holds the
  // number of flush cycles still to follow the current one.
  function automatic logic [HC_FLUSH_CNT_WIDTH-1:0] hc_flush_load(input int cycles);
    return HC_FLUSH_CNT_WIDTH'(cycles - 1);
  endfunction

endpackage

// File: rtl/hc_scoreboard.sv
// Per-register pending-write scoreboard. One bit per architectural register.
// Bit 0 (x0) is never pending. A set and a clear of the same index in one
// cycle leaves the bit set. Reads see only the registered state, so updates
// take effect one cycle later.
module hc_scoreboard #(
  parameter int AWIDTH = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_set_en,
  input  logic [AWIDTH-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [AWIDTH-1:0] i_clr_addr,
  input  logic [AWIDTH-1:0] i_addr_rs1,
  input  logic [AWIDTH-1:0] i_addr_rs2,
  input  logic [AWIDTH-1:0] i_addr_rd,
  output logic              o_pend_rs1,
  output logic              o_pend_rs2,
  output logic              o_pend_rd,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_nxt;

  // Next pending vector: apply the clear first so that a same-index set wins.
  always_comb begin
    // NOTE: start from a full default so no path leaves a bit unassigned (no latch).
    w_pending_nxt = r_pending;
    if (i_clr_en) begin
      w_pending_nxt[i_clr_addr] = 1'b0;
    end
    if (i_set_en) begin
      w_pending_nxt[i_set_addr] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Register the pending vector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: this array is control state, not data storage; every bit must reset.
      r_pending <= '0;
    end else begin
      // NOTE: non-blocking so all flops sample the pre-edge values together.
      r_pending <= w_pending_nxt;
    end
  end

  assign o_pend_rs1 = r_pending[i_addr_rs1];
  assign o_pend_rs2 = r_pending[i_addr_rs2];
  assign o_pend_rd  = r_pending[i_addr_rd];
  assign o_busy     = |r_pending;

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard controller. It tracks pending register writes, stalls
// decode on RAW/WAW hazards, and squashes decode for a programmable number of
// cycles after an execute-stage redirect. It also counts stall cycles in a
// saturating counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int FLUSH_CYCLES = HC_DEFAULT_FLUSH_CYCLES,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 hc_clk,
  input  logic                 hc_rst,
  input  logic                 hc_i_ce,
  input  logic [AWIDTH-1:0]    hc_i_addr_rs1,
  input  logic [AWIDTH-1:0]    hc_i_addr_rs2,
  input  logic [AWIDTH-1:0]    hc_i_addr_rd,
  input  logic                 hc_i_use_rs1,
  input  logic                 hc_i_use_rs2,
  input  logic                 hc_i_write_rd,
  input  logic                 hc_i_retire,
  input  logic [AWIDTH-1:0]    hc_i_retire_addr,
  input  logic                 hc_i_retire_rd,
  input  logic                 hc_i_redirect,
  output logic                 hc_o_stall,
  output logic                 hc_o_flush,
  output logic                 hc_o_issue,
  output logic                 hc_o_read_reg,
  output logic                 hc_o_busy,
  output logic [CNT_WIDTH-1:0] hc_o_stall_count
);

  localparam logic [HC_FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = hc_flush_load(FLUSH_CYCLES);

  hc_state_e                     r_state;
  logic [HC_FLUSH_CNT_WIDTH-1:0] r_flush_cnt;
  logic                          r_flush;
  logic [CNT_WIDTH-1:0]          r_stall_count;

  logic w_pend_rs1;
  logic w_pend_rs2;
  logic w_pend_rd;
  logic w_raw;
  logic w_waw;
  logic w_hazard;
  logic w_idle;
  logic w_set_en;
  logic w_clr_en;

  // Mark rd pending when a writing instruction issues. x0 is never tracked.
  // Squashed instructions clear their bit through the retire path, like
  // committed ones.
  assign w_set_en = hc_o_issue & hc_i_write_rd & (hc_i_addr_rd != '0);
  assign w_clr_en = hc_i_retire & hc_i_retire_rd;

  hc_scoreboard #(
    .AWIDTH (AWIDTH)
  ) u_scoreboard (
    .i_clk      (hc_clk),
    .i_rst      (hc_rst),
    .i_set_en   (w_set_en),
    .i_set_addr (hc_i_addr_rd),
    .i_clr_en   (w_clr_en),
    .i_clr_addr (hc_i_retire_addr),
    .i_addr_rs1 (hc_i_addr_rs1),
    .i_addr_rs2 (hc_i_addr_rs2),
    .i_addr_rd  (hc_i_addr_rd),
    .o_pend_rs1 (w_pend_rs1),
    .o_pend_rs2 (w_pend_rs2),
    .o_pend_rd  (w_pend_rd),
    .o_busy     (hc_o_busy)
  );

  // Hazard detection against the registered scoreboard (no same-cycle bypass).
  assign w_raw    = (hc_i_use_rs1 & w_pend_rs1) | (hc_i_use_rs2 & w_pend_rs2);
  assign w_waw    = hc_i_write_rd & w_pend_rd;
  assign w_hazard = w_raw | w_waw;

  // Decode only stalls or issues in IDLE. A redirect this cycle kills both,
  // because the decoding instruction is younger than the branch.
  assign w_idle        = (r_state == HC_IDLE);
  assign hc_o_stall    = w_idle & hc_i_ce &  w_hazard & ~hc_i_redirect;
  assign hc_o_issue    = w_idle & hc_i_ce & ~w_hazard & ~hc_i_redirect;
  assign hc_o_read_reg = hc_o_issue;
  assign hc_o_flush    = r_flush;

  // Redirect FSM. Flush is registered and follows the redirect by one cycle.
  // A redirect during FLUSH reloads the counter, which extends the flush.
  always_ff @(posedge hc_clk or posedge hc_rst) begin
    if (hc_rst) begin
      r_state     <= HC_IDLE;
      r_flush_cnt <= '0;
      r_flush     <= 1'b0;
    end else begin
      case (r_state)
        HC_IDLE: begin
          if (hc_i_redirect) begin
            r_state     <= HC_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
            r_flush     <= 1'b1;
          end
        end
        HC_FLUSH: begin
          if (hc_i_redirect) begin
            r_flush_cnt <= FLUSH_LOAD;
          end else if (r_flush_cnt == '0) begin
            r_state <= HC_IDLE;
            r_flush <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= HC_IDLE;
          r_flush_cnt <= '0;
          r_flush     <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter for performance monitoring.
  always_ff @(posedge hc_clk or posedge hc_rst) begin
    if (hc_rst) begin
      r_stall_count <= '0;
    end else if (hc_o_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_WIDTH'(1);
    end
  end

  assign hc_o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller. The reference model keeps one
// pending flag per register, the number of flush cycles still owed, and a
// stall tally. Expected outputs come from those alone.
module tb_hazard_controller;

  localparam int AW = 5;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int NREG = 2 ** AW;
  localparam int CNT_MAX = 2 ** CW - 1;

  logic          hc_clk = 1'b0;
  logic          hc_rst;
  logic          hc_i_ce;
  logic [AW-1:0] hc_i_addr_rs1;
  logic [AW-1:0] hc_i_addr_rs2;
  logic [AW-1:0] hc_i_addr_rd;
  logic          hc_i_use_rs1;
  logic          hc_i_use_rs2;
  logic          hc_i_write_rd;
  logic          hc_i_retire;
  logic [AW-1:0] hc_i_retire_addr;
  logic          hc_i_retire_rd;
  logic          hc_i_redirect;
  logic          hc_o_stall;
  logic          hc_o_flush;
  logic          hc_o_issue;
  logic          hc_o_read_reg;
  logic          hc_o_busy;
  logic [CW-1:0] hc_o_stall_count;

  hazard_controller #(
    .AWIDTH       (AW),
    .FLUSH_CYCLES (FC),
    .CNT_WIDTH    (CW)
  ) dut (
    .hc_clk           (hc_clk),
    .hc_rst           (hc_rst),
    .hc_i_ce          (hc_i_ce),
    .hc_i_addr_rs1    (hc_i_addr_rs1),
    .hc_i_addr_rs2    (hc_i_addr_rs2),
    .hc_i_addr_rd     (hc_i_addr_rd),
    .hc_i_use_rs1     (hc_i_use_rs1),
    .hc_i_use_rs2     (hc_i_use_rs2),
    .hc_i_write_rd    (hc_i_write_rd),
    .hc_i_retire      (hc_i_retire),
    .hc_i_retire_addr (hc_i_retire_addr),
    .hc_i_retire_rd   (hc_i_retire_rd),
    .hc_i_redirect    (hc_i_redirect),
    .hc_o_stall       (hc_o_stall),
    .hc_o_flush       (hc_o_flush),
    .hc_o_issue       (hc_o_issue),
    .hc_o_read_reg    (hc_o_read_reg),
    .hc_o_busy        (hc_o_busy),
    .hc_o_stall_count (hc_o_stall_count)
  );

  always #5 hc_clk = ~hc_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit m_pend [NREG];
  int m_flush_rem;
  int m_cnt;

  // Expected outputs for the current cycle.
  bit          e_stall;
  bit          e_issue;
  bit          e_flush;
  bit          e_busy;
  logic [CW-1:0] e_cnt;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    m_flush_rem = 0;
    m_cnt       = 0;
  endtask

  task automatic model_eval();
    bit haz;
    bit in_flush;
    haz = (hc_i_use_rs1 && m_pend[hc_i_addr_rs1]) ||
          (hc_i_use_rs2 && m_pend[hc_i_addr_rs2]) ||
          (hc_i_write_rd && m_pend[hc_i_addr_rd]);
    in_flush = (m_flush_rem > 0);
    e_stall  = hc_i_ce &&  haz && !hc_i_redirect && !in_flush;
    e_issue  = hc_i_ce && !haz && !hc_i_redirect && !in_flush;
    e_flush  = in_flush;
    e_busy   = 1'b0;
    for (int i = 0; i < NREG; i++) if (m_pend[i]) e_busy = 1'b1;
    e_cnt = CW'(m_cnt);
  endtask

  task automatic model_update();
    if (hc_i_retire && hc_i_retire_rd) m_pend[hc_i_retire_addr] = 1'b0;
    if (e_issue && hc_i_write_rd)      m_pend[hc_i_addr_rd]     = 1'b1;
    m_pend[0] = 1'b0;
    if (e_stall && m_cnt < CNT_MAX) m_cnt++;
    if (hc_i_redirect)        m_flush_rem = FC;
    else if (m_flush_rem > 0) m_flush_rem--;
  endtask

  // Drive one cycle of inputs (called just after a falling edge), let them
  // settle, then compute the expected outputs.
  task automatic drive(input bit ce, input int rs1, input int rs2, input int rd,
                       input bit u1, input bit u2, input bit wr,
                       input bit ret, input int raddr, input bit rrd, input bit redir);
    hc_i_ce          = ce;
    hc_i_addr_rs1    = AW'(rs1);
    hc_i_addr_rs2    = AW'(rs2);
    hc_i_addr_rd     = AW'(rd);
    hc_i_use_rs1     = u1;
    hc_i_use_rs2     = u2;
    hc_i_write_rd    = wr;
    hc_i_retire      = ret;
    hc_i_retire_addr = AW'(raddr);
    hc_i_retire_rd   = rrd;
    hc_i_redirect    = redir;
    #1;
    model_eval();
  endtask

  task automatic finish_cycle();
    model_update();
    @(negedge hc_clk);
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    finish_cycle();
  endtask

  task automatic test_reset();
    hc_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    checks++;
    if ({hc_o_stall, hc_o_flush, hc_o_issue, hc_o_read_reg, hc_o_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {hc_o_stall, hc_o_flush, hc_o_issue, hc_o_read_reg, hc_o_busy});
    end
    checks++;
    if (hc_o_stall_count !== '0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", hc_o_stall_count);
    end
    @(negedge hc_clk);
    @(negedge hc_clk);
    hc_rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (hc_o_issue !== 1'b1) begin errors++; $display("FAIL midrst_issue got=%b exp=1", hc_o_issue); end
    finish_cycle();
    for (int k = 0; k < 7; k++) begin
      drive(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (hc_o_stall !== e_stall) begin errors++; $display("FAIL midrst_stall k=%0d got=%b exp=%b", k, hc_o_stall, e_stall); end
      finish_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (hc_o_stall_count !== 4'd7) begin errors++; $display("FAIL midrst_count7 got=%0d exp=7", hc_o_stall_count); end
    checks++;
    if (hc_o_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b exp=1", hc_o_busy); end
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hc_o_flush !== 1'b1) begin errors++; $display("FAIL midrst_preflush got=%b exp=1", hc_o_flush); end
    // Async reset between clock edges must clear state immediately.
    hc_rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (hc_o_flush !== 1'b0) begin errors++; $display("FAIL midrst_flush got=%b exp=0", hc_o_flush); end
    checks++;
    if (hc_o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy0 got=%b exp=0", hc_o_busy); end
    checks++;
    if (hc_o_stall_count !== '0) begin errors++; $display("FAIL midrst_count0 got=%0d exp=0", hc_o_stall_count); end
    @(negedge hc_clk);
    hc_rst = 1'b0;
    // A read of the old pending register must no longer stall.
    drive(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hc_o_issue !== 1'b1) begin errors++; $display("FAIL midrst_after_issue got=%b exp=1", hc_o_issue); end
    finish_cycle();
  endtask

  task automatic test_raw();
    drive(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    finish_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1, 3, 0, 0, 1, 0, 0, (k == 2), 3, 1, 0);
      checks++;
      if (hc_o_stall !== 1'b1 || hc_o_issue !== 1'b0) begin
        errors++; $display("FAIL raw_stall k=%0d got=%b%b exp=10", k, hc_o_stall, hc_o_issue);
      end
      finish_cycle();
    end
    drive(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hc_o_stall !== 1'b0 || hc_o_issue !== 1'b1 || hc_o_read_reg !== 1'b1) begin
      errors++; $display("FAIL raw_release got=%b%b%b exp=011", hc_o_stall, hc_o_issue, hc_o_read_reg);
    end
    checks++;
    if (hc_o_stall_count !== e_cnt) begin errors++; $display("FAIL raw_count got=%0d exp=%0d", hc_o_stall_count, e_cnt); end
    finish_cycle();
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (hc_o_issue !== 1'b1) begin errors++; $display("FAIL x0_issue got=%b exp=1", hc_o_issue); end
    finish_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      checks++;
      if (hc_o_stall !== 1'b0 || hc_o_busy !== 1'b0) begin
        errors++; $display("FAIL x0_nostall k=%0d got stall=%b busy=%b exp 0 0", k, hc_o_stall, hc_o_busy);
      end
      finish_cycle();
    end
  endtask

  task automatic test_waw();
    drive(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    finish_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 7, 0, 0, 1, (k == 1), 7, 1, 0);
      checks++;
      if (hc_o_stall !== 1'b1 || hc_o_issue !== 1'b0) begin
        errors++; $display("FAIL waw_stall k=%0d got=%b%b exp=10", k, hc_o_stall, hc_o_issue);
      end
      finish_cycle();
    end
    drive(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (hc_o_issue !== 1'b1) begin errors++; $display("FAIL waw_issue got=%b exp=1", hc_o_issue); end
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0);
    checks++;
    if (hc_o_busy !== 1'b1) begin errors++; $display("FAIL waw_reset_bit got=%b exp=1", hc_o_busy); end
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hc_o_busy !== 1'b0) begin errors++; $display("FAIL waw_clean got=%b exp=0", hc_o_busy); end
    finish_cycle();
  endtask

  task automatic test_redirect();
    // Single redirect, then a double redirect that extends the flush.
    bit redir_a [4] = '{1, 0, 0, 0};
    bit flush_a [4] = '{0, 1, 1, 0};
    bit redir_b [5] = '{1, 1, 0, 0, 0};
    bit flush_b [5] = '{0, 1, 1, 1, 0};
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 2, 0, 1, 1, 0, 0, 0, 0, redir_a[k]);
      checks++;
      if (hc_o_flush !== flush_a[k] || hc_o_issue !== (!flush_a[k] && !redir_a[k]) || hc_o_stall !== 1'b0) begin
        errors++; $display("FAIL redirect_single k=%0d got flush=%b issue=%b stall=%b", k, hc_o_flush, hc_o_issue, hc_o_stall);
      end
      finish_cycle();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 2, 0, 1, 1, 0, 0, 0, 0, redir_b[k]);
      checks++;
      if (hc_o_flush !== flush_b[k] || hc_o_issue !== (!flush_b[k] && !redir_b[k])) begin
        errors++; $display("FAIL redirect_extend k=%0d got flush=%b issue=%b", k, hc_o_flush, hc_o_issue);
      end
      finish_cycle();
    end
  endtask

  task automatic test_collision();
    drive(1, 0, 0, 9, 0, 0, 1, 1, 9, 1, 0);
    checks++;
    if (hc_o_issue !== 1'b1) begin errors++; $display("FAIL coll_issue got=%b exp=1", hc_o_issue); end
    finish_cycle();
    drive(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hc_o_busy !== 1'b1 || hc_o_stall !== 1'b1) begin
      errors++; $display("FAIL coll_set_wins got busy=%b stall=%b exp 1 1", hc_o_busy, hc_o_stall);
    end
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0);
    finish_cycle();
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0);
    finish_cycle();
    for (int k = 0; k < NREG / 2 + 3; k++) begin
      drive(1, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0);
      finish_cycle();
    end
    for (int k = 0; k < CNT_MAX + 4; k++) begin
      drive(1, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0);
      finish_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0);
    checks++;
    if (hc_o_stall_count !== 4'hF) begin errors++; $display("FAIL sat_count got=%0d exp=15", hc_o_stall_count); end
    finish_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 11) == 0);
      checks++;
      if (hc_o_stall !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, hc_o_stall, e_stall); end
      checks++;
      if (hc_o_issue !== e_issue) begin errors++; $display("FAIL rnd_issue n=%0d got=%b exp=%b", n, hc_o_issue, e_issue); end
      checks++;
      if (hc_o_read_reg !== e_issue) begin errors++; $display("FAIL rnd_read_reg n=%0d got=%b exp=%b", n, hc_o_read_reg, e_issue); end
      checks++;
      if (hc_o_flush !== e_flush) begin errors++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, hc_o_flush, e_flush); end
      checks++;
      if (hc_o_busy !== e_busy) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, hc_o_busy, e_busy); end
      checks++;
      if (hc_o_stall_count !== e_cnt) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, hc_o_stall_count, e_cnt); end
      finish_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_raw();
    test_x0();
    test_waw();
    test_redirect();
    test_collision();
    test_saturation();
    idle_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
